// File: rtl/select_scan_encoder_pkg.sv
// select_scan_encoder_pkg: shared state encoding and default sizing for the select scan encoder
package select_scan_encoder_pkg;
  localparam int DEFAULT_NUM_INPUT = 4;
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/select_scan_encoder_if.sv
// select_scan_encoder_if: capture handshake, index handshake and status flags of the select scan encoder
interface select_scan_encoder_if #(
  parameter int NUM_INPUT = 4
);
  localparam int ADDR_W = $clog2(NUM_INPUT);
  logic                 in_valid;
  logic                 out_ready;
  logic [NUM_INPUT-1:0] in_select;
  logic                 out_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    out_address;
  logic                 out_last;
  logic                 out_multi;
  logic                 out_error;
  modport slave (
    input  in_valid, in_select, in_ready,
    output out_ready, out_valid, out_address, out_last, out_multi, out_error
  );
  modport master (
    output in_valid, in_select, in_ready,
    input  out_ready, out_valid, out_address, out_last, out_multi, out_error
  );
endinterface

// File: rtl/select_scan_encoder_lowest_set_index.sv
// lowest_set_index: index of the lowest set bit of a vector, plus a flag for exactly one bit set
module lowest_set_index #(
  parameter  int NUM_INPUT = 4,
  localparam int ADDR_W    = $clog2(NUM_INPUT)
) (
  input  logic [NUM_INPUT-1:0] vec_i,
  output logic [ADDR_W-1:0]    index_o,
  output logic                 one_left_o
);
  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    index_o = '0;
    for (int i = NUM_INPUT - 1; i >= 0; i--)
      if (vec_i[i]) index_o = ADDR_W'(i);
  end
  assign one_left_o = (|vec_i) && !(|(vec_i & (vec_i - NUM_INPUT'(1))));
endmodule

// File: rtl/select_scan_encoder.sv
// select_scan_encoder: captures a select vector and emits the index of every set bit, lowest first, one per handshake
module select_scan_encoder
  import select_scan_encoder_pkg::*;
#(
  parameter int NUM_INPUT = DEFAULT_NUM_INPUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  select_scan_encoder_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_INPUT);
  state_e               state_q, state_d;
  logic [NUM_INPUT-1:0] pending_q, pending_d;
  logic                 multi_q, multi_d;
  logic                 error_q, error_d;
  logic [ADDR_W-1:0]    idx;
  logic                 one_left;
  lowest_set_index #(.NUM_INPUT(NUM_INPUT)) u_lsi (
    .vec_i      (pending_q),
    .index_o    (idx),
    .one_left_o (one_left)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      multi_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      multi_q   <= multi_d;
      error_q   <= error_d;
    end
  end
  // x & (x-1) clears the lowest set bit, i.e. the index just handed off.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    multi_d   = multi_q;
    error_d   = 1'b0;
    if (state_q == IDLE && bus.in_valid) begin
      if (|bus.in_select) begin
        pending_d = bus.in_select;
        multi_d   = |(bus.in_select & (bus.in_select - NUM_INPUT'(1)));
        state_d   = SCAN;
      end else begin
        error_d   = 1'b1;
      end
    end else if (state_q == SCAN && bus.in_ready) begin
      pending_d = pending_q & (pending_q - NUM_INPUT'(1));
      state_d   = one_left ? IDLE : SCAN;
    end
  end
  assign bus.out_ready   = state_q == IDLE;
  assign bus.out_valid   = state_q == SCAN;
  assign bus.out_address = idx;
  assign bus.out_last    = one_left && state_q == SCAN;
  assign bus.out_multi   = multi_q;
  assign bus.out_error   = error_q;
endmodule

// File: tb/tb_select_scan_encoder.sv
// tb_select_scan_encoder: directed checks of capture, scan order, back-pressure, error pulse and reset
module tb_select_scan_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  select_scan_encoder_if #(.NUM_INPUT(4)) b4 ();
  select_scan_encoder_if #(.NUM_INPUT(8)) b8 ();
  select_scan_encoder #(.NUM_INPUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  select_scan_encoder #(.NUM_INPUT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat4(input string tag, input logic v, input logic [1:0] a, input logic l);
    chk({tag, " valid"}, 32'(b4.out_valid), 32'(v));
    chk({tag, " ready"}, 32'(b4.out_ready), 32'(!v));
    if (v) begin
      chk({tag, " addr"}, 32'(b4.out_address), 32'(a));
      chk({tag, " last"}, 32'(b4.out_last), 32'(l));
    end
  endtask
  task automatic nxt;
    @(negedge clk);
  endtask
  initial begin
    b4.in_valid = 1'b0; b4.in_select = '0; b4.in_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_select = '0; b8.in_ready = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
    nxt();
    beat4("reset", 1'b0, 2'd0, 1'b0);
    chk("reset addr", 32'(b4.out_address), 32'd0);
    chk("reset last", 32'(b4.out_last), 32'd0);
    chk("reset multi", 32'(b4.out_multi), 32'd0);
    chk("reset error", 32'(b4.out_error), 32'd0);
    chk("reset8 ready", 32'(b8.out_ready), 32'd1);
    // single bit 0100
    b4.in_valid = 1'b1; b4.in_select = 4'b0100; b4.in_ready = 1'b1;
    nxt();
    b4.in_valid = 1'b0;
    beat4("one-hot", 1'b1, 2'd2, 1'b1);
    chk("one-hot multi", 32'(b4.out_multi), 32'd0);
    nxt();
    beat4("one-hot done", 1'b0, 2'd0, 1'b0);
    // multi-hot 1011, no back-pressure
    b4.in_valid = 1'b1; b4.in_select = 4'b1011;
    nxt();
    b4.in_valid = 1'b0;
    beat4("1011 b0", 1'b1, 2'd0, 1'b0);
    chk("1011 multi", 32'(b4.out_multi), 32'd1);
    nxt();
    beat4("1011 b1", 1'b1, 2'd1, 1'b0);
    nxt();
    beat4("1011 b2", 1'b1, 2'd3, 1'b1);
    nxt();
    beat4("1011 done", 1'b0, 2'd0, 1'b0);
    chk("multi held", 32'(b4.out_multi), 32'd1);
    // zero vector: one-cycle error, multi untouched
    b4.in_valid = 1'b1; b4.in_select = 4'b0000;
    nxt();
    b4.in_valid = 1'b0;
    chk("zero error", 32'(b4.out_error), 32'd1);
    beat4("zero", 1'b0, 2'd0, 1'b0);
    chk("zero multi kept", 32'(b4.out_multi), 32'd1);
    nxt();
    chk("zero error cleared", 32'(b4.out_error), 32'd0);
    // 1010 with downstream stalled for three cycles
    b4.in_valid = 1'b1; b4.in_select = 4'b1010; b4.in_ready = 1'b0;
    nxt();
    b4.in_select = 4'b0000;
    beat4("stall c1", 1'b1, 2'd1, 1'b0);
    chk("stall multi", 32'(b4.out_multi), 32'd1);
    nxt();
    beat4("stall c2", 1'b1, 2'd1, 1'b0);
    chk("scan ignores zero", 32'(b4.out_error), 32'd0);
    b4.in_valid = 1'b0;
    nxt();
    beat4("stall c3", 1'b1, 2'd1, 1'b0);
    b4.in_ready = 1'b1;
    nxt();
    beat4("stall after hs", 1'b1, 2'd3, 1'b1);
    nxt();
    beat4("stall done", 1'b0, 2'd0, 1'b0);
    // async reset in the middle of a scan of 1100
    b4.in_valid = 1'b1; b4.in_select = 4'b1100; b4.in_ready = 1'b0;
    nxt();
    b4.in_valid = 1'b0;
    beat4("pre-reset", 1'b1, 2'd2, 1'b0);
    chk("pre-reset multi", 32'(b4.out_multi), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    beat4("in reset", 1'b0, 2'd0, 1'b0);
    chk("in reset multi", 32'(b4.out_multi), 32'd0);
    b4.in_ready = 1'b1;
    nxt();
    rst_n = 1'b1;
    nxt();
    beat4("post-reset c1", 1'b0, 2'd0, 1'b0);
    nxt();
    beat4("post-reset c2", 1'b0, 2'd0, 1'b0);
    // all-ones on the 8-wide instance
    b8.in_valid = 1'b1; b8.in_select = 8'hFF; b8.in_ready = 1'b1;
    nxt();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("ff valid", 32'(b8.out_valid), 32'd1);
      chk("ff addr", 32'(b8.out_address), 32'(i));
      chk("ff last", 32'(b8.out_last), 32'(i == 7));
      nxt();
    end
    chk("ff done valid", 32'(b8.out_valid), 32'd0);
    chk("ff done ready", 32'(b8.out_ready), 32'd1);
    chk("ff multi", 32'(b8.out_multi), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
